// File: rtl/can_tx_mailbox_scheduler.sv
// rtl/can_tx_mailbox_scheduler.sv - CAN transmit mailbox arbiter with retry, abort and pre-emption
module can_tx_mailbox_scheduler #(
  parameter int NUM_MB      = 4,
  parameter int MAX_RETRIES = 8,
  localparam int IW         = $clog2(NUM_MB)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable_i,
  input  logic              load_valid_i,
  input  logic [IW-1:0]     load_index_i,
  input  logic [10:0]       load_identifier_i,
  input  logic [3:0]        load_dlc_i,
  input  logic [63:0]       load_data_i,
  input  logic              load_frame_type_i,
  input  logic [NUM_MB-1:0] abort_mask_i,
  input  logic              bus_idle_i,
  input  logic              tx_done_i,
  input  logic              tx_error_i,
  input  logic              arb_lost_i,
  output logic              tx_start_o,
  output logic [10:0]       tx_identifier_o,
  output logic [3:0]        tx_dlc_o,
  output logic [63:0]       tx_data_o,
  output logic              tx_frame_type_o,
  output logic [NUM_MB-1:0] mb_pending_o,
  output logic              load_busy_o,
  output logic              done_pulse_o,
  output logic              fail_pulse_o,
  output logic [IW-1:0]     active_index_o,
  output logic [3:0]        retry_count_o
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SELECT    = 2'd1;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd2;
  localparam logic [1:0] ST_TRANSMIT  = 2'd3;
  localparam logic [3:0] MAX_R        = 4'(MAX_RETRIES);

  logic [1:0]        state_q, state_d;
  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [10:0]       mb_id_q   [NUM_MB];
  logic [3:0]        mb_dlc_q  [NUM_MB];
  logic [63:0]       mb_data_q [NUM_MB];
  logic              mb_type_q [NUM_MB];
  logic [IW-1:0]     active_q, active_d;
  logic [3:0]        retry_q, retry_d, retry_inc;
  logic [10:0]       tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic              tx_type_q, tx_type_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic              start_go;
  logic              clear_active;
  logic              holds_active;
  logic              load_accept;
  logic [NUM_MB-1:0] abort_eff;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [10:0]       win_id;

  // The active mailbox is owned by the transmitter path from WAIT_IDLE until the frame resolves.
  assign holds_active = (state_q == ST_WAIT_IDLE) || (state_q == ST_TRANSMIT);
  assign load_busy_o  = load_valid_i && holds_active && (load_index_i == active_q);
  assign load_accept  = load_valid_i && !load_busy_o && !abort_mask_i[load_index_i];
  assign retry_inc    = (retry_q == MAX_R) ? retry_q : retry_q + 4'd1;

  assign tx_start_o      = start_go & enable_i;
  assign tx_identifier_o = tx_id_q;
  assign tx_dlc_o        = tx_dlc_q;
  assign tx_data_o       = tx_data_q;
  assign tx_frame_type_o = tx_type_q;
  assign mb_pending_o    = pending_q;
  assign done_pulse_o    = done_q;
  assign fail_pulse_o    = fail_q;
  assign active_index_o  = active_q;
  assign retry_count_o   = retry_q;

  // Lowest identifier among pending mailboxes wins; strict compare keeps ties on the lower index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && (!win_found || (mb_id_q[i] < win_id))) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_id    = mb_id_q[i];
      end
    end
  end

  // Scheduler FSM: arbitration, bus-idle wait and resolution of the transmitter outcome.
  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    retry_d      = retry_q;
    tx_id_d      = tx_id_q;
    tx_dlc_d     = tx_dlc_q;
    tx_data_d    = tx_data_q;
    tx_type_d    = tx_type_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    start_go     = 1'b0;
    clear_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (!win_found) begin
          state_d = ST_IDLE;
        end else begin
          active_d  = win_idx;
          tx_id_d   = mb_id_q[win_idx];
          tx_dlc_d  = mb_dlc_q[win_idx];
          tx_data_d = mb_data_q[win_idx];
          tx_type_d = mb_type_q[win_idx];
          // A different winner (including a pre-empted frame coming back) starts a fresh retry budget.
          if (win_idx != active_q) retry_d = 4'd0;
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (!pending_q[active_q] || abort_mask_i[active_q]) begin
          state_d = ST_IDLE;
        end else if (bus_idle_i) begin
          start_go = 1'b1;
          state_d  = ST_TRANSMIT;
        end
      end
      default: begin
        if (tx_done_i) begin
          clear_active = 1'b1;
          done_d       = 1'b1;
          retry_d      = 4'd0;
          state_d      = ST_IDLE;
        end else if (tx_error_i) begin
          if (retry_inc == MAX_R) begin
            clear_active = 1'b1;
            fail_d       = 1'b1;
            retry_d      = 4'd0;
            state_d      = ST_IDLE;
          end else begin
            retry_d = retry_inc;
            state_d = ST_SELECT;
          end
        end else if (arb_lost_i) begin
          state_d = ST_SELECT;
        end
      end
    endcase
  end

  // Pending bits: load sets, abort clears (abort wins), the frame in flight is immune to abort.
  always_comb begin
    pending_d = pending_q;
    if (load_accept) pending_d[load_index_i] = 1'b1;
    abort_eff = abort_mask_i;
    if (state_q == ST_TRANSMIT) abort_eff[active_q] = 1'b0;
    pending_d = pending_d & ~abort_eff;
    if (clear_active) pending_d[active_q] = 1'b0;
  end

  // Mailbox storage, written only by accepted loads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id_q[i]   <= '0;
        mb_dlc_q[i]  <= '0;
        mb_data_q[i] <= '0;
        mb_type_q[i] <= 1'b0;
      end
    end else if (!enable_i) begin
      for (int i = 0; i < NUM_MB; i++) begin
        mb_id_q[i]   <= '0;
        mb_dlc_q[i]  <= '0;
        mb_data_q[i] <= '0;
        mb_type_q[i] <= 1'b0;
      end
    end else if (load_accept) begin
      mb_id_q[load_index_i]   <= load_identifier_i;
      mb_dlc_q[load_index_i]  <= load_dlc_i;
      mb_data_q[load_index_i] <= load_data_i;
      mb_type_q[load_index_i] <= load_frame_type_i;
    end
  end

  // Control and latched transmit fields, cleared by reset or by enable going low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      active_q  <= '0;
      retry_q   <= '0;
      tx_id_q   <= '0;
      tx_dlc_q  <= '0;
      tx_data_q <= '0;
      tx_type_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else if (!enable_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      active_q  <= '0;
      retry_q   <= '0;
      tx_id_q   <= '0;
      tx_dlc_q  <= '0;
      tx_data_q <= '0;
      tx_type_q <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      retry_q   <= retry_d;
      tx_id_q   <= tx_id_d;
      tx_dlc_q  <= tx_dlc_d;
      tx_data_q <= tx_data_d;
      tx_type_q <= tx_type_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

endmodule
